// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Sequences the 8-bit instruction memory of the lab single-cycle CPU.
//   The block owns the program counter, latches the IMEM data into an
//   instruction register, and hands each instruction to the datapath with
//   a valid/ready handshake. It runs freely or one instruction per step,
//   halts after the last program word, and restarts on request.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   run           level, 1 = free-run mode
//   step          level, each rising edge requests one instruction
//   restart       synchronous, PC to 0 and back to IDLE
//   instruction   combinational IMEM data for read_address
//   exec_ready    datapath accepts ir this cycle
//   read_address  IMEM address (the program counter)
//   ir            latched instruction
//   opcode/rs/rt/rd  instruction fields ir[7:6]/[5:4]/[3:2]/[1:0]
//   ir_valid      ir holds an instruction not yet accepted
//   halted        program finished
//   retired       number of accepted instructions, wraps mod 256

module fetch_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int PROG_LEN = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              step,
    input  logic              restart,
    input  logic [7:0]        instruction,
    input  logic              exec_ready,
    output logic [ADDR_W-1:0] read_address,
    output logic [7:0]        ir,
    output logic [1:0]        opcode,
    output logic [1:0]        rs,
    output logic [1:0]        rt,
    output logic [1:0]        rd,
    output logic              ir_valid,
    output logic              halted,
    output logic [7:0]        retired
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_t;

    // Address of the final program word; PROG_LEN <= 2^ADDR_W keeps it in range.
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        ir_q;
    logic              ir_valid_q;
    logic              halted_q;
    logic [7:0]        retired_q;
    logic              step_q;
    logic              step_rise;

    assign step_rise = step & ~step_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            retired_q  <= '0;
            step_q     <= 1'b0;
        end else begin
            // Step history tracks every cycle so a restart edge does not
            // leave a stale low that would fake a rising edge later.
            step_q <= step;

            if (restart) begin
                state_q    <= IDLE;
                pc_q       <= '0;
                ir_valid_q <= 1'b0;
                halted_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (run || step_rise) begin
                            state_q <= FETCH;
                        end
                    end

                    FETCH: begin
                        ir_q       <= instruction;
                        ir_valid_q <= 1'b1;
                        state_q    <= ISSUE;
                    end

                    ISSUE: begin
                        if (exec_ready) begin
                            retired_q  <= retired_q + 8'd1;
                            ir_valid_q <= 1'b0;
                            if (pc_q == LAST_PC) begin
                                halted_q <= 1'b1;
                                state_q  <= HALT;
                            end else begin
                                pc_q    <= pc_q + ADDR_W'(1);
                                state_q <= run ? FETCH : IDLE;
                            end
                        end
                    end

                    HALT: begin
                        // Only restart or reset leaves this state.
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign read_address = pc_q;
    assign ir           = ir_q;
    assign opcode       = ir_q[7:6];
    assign rs           = ir_q[5:4];
    assign rt           = ir_q[3:2];
    assign rd           = ir_q[1:0];
    assign ir_valid     = ir_valid_q;
    assign halted       = halted_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a 5-word program instance plus a
// PROG_LEN=1 instance. Expected instructions are queued when a request is
// driven and checked by a monitor whenever the DUT offers ir with ready high.

module tb_fetch_sequencer;

    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              run, step, restart, exec_ready;
    logic [7:0]        instruction;
    logic [ADDR_W-1:0] read_address;
    logic [7:0]        ir;
    logic [1:0]        opcode, rs, rt, rd;
    logic              ir_valid, halted;
    logic [7:0]        retired;

    logic              run1, step1, restart1;
    logic [7:0]        instruction1;
    logic [ADDR_W-1:0] read_address1;
    logic [7:0]        ir1;
    logic [1:0]        opcode1, rs1, rt1, rd1;
    logic              ir_valid1, halted1;
    logic [7:0]        retired1;

    logic [7:0] mem [256];
    assign instruction  = mem[read_address];
    assign instruction1 = (read_address1 == '0) ? 8'h49 : 8'hC1;

    fetch_sequencer #(.ADDR_W(ADDR_W), .PROG_LEN(5)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step), .restart(restart),
        .instruction(instruction), .exec_ready(exec_ready),
        .read_address(read_address), .ir(ir), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .ir_valid(ir_valid), .halted(halted), .retired(retired)
    );

    fetch_sequencer #(.ADDR_W(ADDR_W), .PROG_LEN(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .run(run1), .step(step1), .restart(restart1),
        .instruction(instruction1), .exec_ready(exec_ready),
        .read_address(read_address1), .ir(ir1), .opcode(opcode1), .rs(rs1), .rt(rt1),
        .rd(rd1), .ir_valid(ir_valid1), .halted(halted1), .retired(retired1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         last_acc = 0;
    bit         have_last = 1'b0;
    bit         spacing_on = 1'b0;
    logic [7:0] e;

    always @(posedge clk) cyc++;

    // Scoreboard: the DUT accepts at the next rising edge whenever this holds.
    always @(negedge clk) begin
        if (reset_n && ir_valid && exec_ready) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ir", 32'(ir), 32'(e));
                chk("fields", 32'({opcode, rs, rt, rd}), 32'(e));
                if (e == 8'hA9) begin
                    chk("A9_opcode", 32'(opcode), 2);
                    chk("A9_rs", 32'(rs), 2);
                    chk("A9_rt", 32'(rt), 2);
                    chk("A9_rd", 32'(rd), 1);
                end
            end
            if (spacing_on && have_last) chk("spacing", 32'(cyc - last_acc), 2);
            last_acc  = cyc;
            have_last = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'h49; mem[1] = 8'hC1; mem[2] = 8'h18; mem[3] = 8'hA9; mem[4] = 8'h4D;
        mem[5] = 8'hFF;

        reset_n = 1'b0; run = 1'b1; step = 1'b0; restart = 1'b0; exec_ready = 1'b1;
        run1 = 1'b0; step1 = 1'b0; restart1 = 1'b0;

        // Reset values with no clock edge yet, then held across edges with run=1.
        #3;
        chk("rst_pc", 32'(read_address), 0);
        chk("rst_ir", 32'(ir), 0);
        chk("rst_valid", 32'(ir_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_retired", 32'(retired), 0);
        #19;
        chk("rst_hold_pc", 32'(read_address), 0);
        chk("rst_hold_valid", 32'(ir_valid), 0);

        // Free-run through the whole program.
        exp_q.push_back(8'h49); exp_q.push_back(8'hC1); exp_q.push_back(8'h18);
        exp_q.push_back(8'hA9); exp_q.push_back(8'h4D);
        spacing_on = 1'b1;
        reset_n = 1'b1;
        tick();
        chk("first_fetch_valid", 32'(ir_valid), 0);
        tick();
        chk("first_issue_valid", 32'(ir_valid), 1);
        chk("first_issue_ir", 32'(ir), 32'h49);
        for (int i = 0; i < 40 && !halted; i++) tick();
        spacing_on = 1'b0;
        chk("run_halted", 32'(halted), 1);
        chk("run_retired", 32'(retired), 5);
        chk("run_pc", 32'(read_address), 4);
        chk("run_valid", 32'(ir_valid), 0);
        chk("run_drained", 32'(exp_q.size()), 0);
        step = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        step = 1'b0;
        chk("halt_ignores_retired", 32'(retired), 5);
        chk("halt_ignores_halted", 32'(halted), 1);

        // Restart from HALT, then one run request dropped after the first edge.
        run = 1'b0; restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_halted", 32'(halted), 0);
        chk("restart_pc", 32'(read_address), 0);
        chk("restart_retired", 32'(retired), 5);
        chk("restart_ir_kept", 32'(ir), 32'h4D);
        tick(); tick();
        chk("restart_idle", 32'(ir_valid), 0);
        exp_q.push_back(8'h49);
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 10 && retired != 8'd6; i++) tick();
        chk("rerun_retired", 32'(retired), 6);
        chk("rerun_pc", 32'(read_address), 1);
        tick(); tick(); tick();
        chk("rerun_idle_valid", 32'(ir_valid), 0);
        chk("rerun_idle_pc", 32'(read_address), 1);

        // Single-step: three pulses, the last held high long.
        restart = 1'b1; tick(); restart = 1'b0;
        exp_q.push_back(8'h49); exp_q.push_back(8'hC1); exp_q.push_back(8'h18);
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            for (int i = 0; i < ((p == 2) ? 10 : 3); i++) tick();
            step = 1'b0;
            for (int i = 0; i < 4; i++) tick();
        end
        chk("step_pc", 32'(read_address), 3);
        chk("step_retired", 32'(retired), 9);
        chk("step_valid", 32'(ir_valid), 0);
        chk("step_drained", 32'(exp_q.size()), 0);

        // Backpressure on the second word.
        restart = 1'b1; tick(); restart = 1'b0;
        exp_q.push_back(8'h49);
        step = 1'b1; tick(); step = 1'b0;
        for (int i = 0; i < 10 && retired != 8'd10; i++) tick();
        chk("bp_pre_retired", 32'(retired), 10);
        exec_ready = 1'b0;
        exp_q.push_back(8'hC1);
        step = 1'b1; tick(); step = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(ir_valid), 1);
            chk("bp_ir", 32'(ir), 32'hC1);
            chk("bp_pc", 32'(read_address), 1);
            chk("bp_retired", 32'(retired), 10);
        end
        exec_ready = 1'b1;
        tick();
        chk("bp_accept_retired", 32'(retired), 11);
        chk("bp_accept_pc", 32'(read_address), 2);
        chk("bp_accept_valid", 32'(ir_valid), 0);

        // Restart and a step rising edge on the same clock edge.
        restart = 1'b1; step = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_pc", 32'(read_address), 0);
        chk("rs_valid", 32'(ir_valid), 0);
        tick(); tick(); tick();
        chk("rs_no_fetch_valid", 32'(ir_valid), 0);
        chk("rs_no_fetch_retired", 32'(retired), 11);
        chk("rs_no_fetch_pc", 32'(read_address), 0);
        step = 1'b0;

        // Asynchronous reset in the middle of ISSUE.
        exec_ready = 1'b0; run = 1'b1;
        tick(); tick();
        chk("ar_issue_valid", 32'(ir_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(ir_valid), 0);
        chk("ar_retired", 32'(retired), 0);
        chk("ar_pc", 32'(read_address), 0);
        exec_ready = 1'b1;
        tick();
        chk("ar_no_accept", 32'(retired), 0);
        run = 1'b0;
        reset_n = 1'b1;

        // PROG_LEN=1 instance halts after one accept.
        run1 = 1'b1;
        for (int i = 0; i < 10 && !halted1; i++) tick();
        chk("p1_halted", 32'(halted1), 1);
        chk("p1_retired", 32'(retired1), 1);
        chk("p1_ir", 32'(ir1), 32'h49);
        chk("p1_pc", 32'(read_address1), 0);
        chk("p1_valid", 32'(ir_valid1), 0);
        tick(); tick(); tick();
        chk("p1_stays_retired", 32'(retired1), 1);
        run1 = 1'b0;

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control block that sequences the 8-bit instruction memory for the lab single-cycle CPU.
- Owns the program counter and drives the IMEM read address. Latches the returned instruction into an instruction register.
- Issues each instruction to the datapath with a valid/ready handshake.
- Supports free-run and single-step (button) modes. Halts after the last program word and restarts on request.

Parameters:
- ADDR_W, 8, width of PC / IMEM read address.
- PROG_LEN, 5, number of valid program words. Last executed address = PROG_LEN-1. Legal range 1..2^ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = free-run mode.
- step  in  1  level, synchronous (already debounced); each rising edge requests one instruction.
- restart  in  1  synchronous; 1 = PC to 0, leave HALT.
- instruction  in  8  combinational IMEM data for read_address.
- exec_ready  in  1  datapath accepts ir this cycle.
- read_address  out  ADDR_W  IMEM address; equals pc.
- ir  out  8  latched instruction.
- opcode  out  2  ir[7:6].
- rs  out  2  ir[5:4].
- rt  out  2  ir[3:2].
- rd  out  2  ir[1:0].
- ir_valid  out  1  ir holds an unaccepted instruction.
- halted  out  1  program finished.
- retired  out  8  count of accepted instructions, wraps mod 256.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, pc=0, ir=0x00, ir_valid=0, halted=0, retired=0, step_q=0. Outputs valid immediately; no clock needed.
- step_rise = step & ~step_q. step_q is registered every cycle.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE:
  - run=1 or step_rise=1 -> FETCH.
  - Both asserted -> FETCH, treated as run.
- FETCH (one cycle): read_address=pc; at edge: ir<=instruction, -> ISSUE.
- ISSUE:
  - ir_valid=1. ir is stable until accepted.
  - Accept occurs at an edge with exec_ready=1. On accept: retired<=retired+1.
  - If pc==PROG_LEN-1 -> HALT, pc unchanged.
  - Else pc<=pc+1, and next state is FETCH if run=1, otherwise IDLE.
  - exec_ready=0 -> stay in ISSUE.
- HALT: halted=1, ir_valid=0. Ignores run and step.
- restart=1 at any edge, in any state, forces: pc=0, state=IDLE, ir_valid=0, halted=0. ir and retired are kept. restart has priority over all other inputs except reset_n.
- step_rise outside IDLE is dropped (not queued).
- Dropping run mid-program finishes the current ISSUE, then goes to IDLE.
- Latency: request sampled at edge k -> FETCH in cycle k..k+1 -> ir_valid=1 after edge k+1. If exec_ready=1 during that cycle, accept at edge k+2.
- Free-run with exec_ready held at 1: one instruction accepted every 2 cycles.
- pc increments with wrap at 2^ADDR_W. This never occurs when PROG_LEN <= 2^ADDR_W.
- PROG_LEN=1: first accept -> HALT.
- Reset asserted mid-ISSUE: ir_valid drops asynchronously; no accept is counted.

Test Plan:
- Reset check: hold reset_n=0 with run=1 -> pc=0, ir=0x00, ir_valid=0, halted=0, retired=0. Release -> FETCH on the first edge.
- Free-run: program 0x49,0xC1,0x18,0xA9,0x4D, run=1, exec_ready=1.
  - ir_valid pulses show 0x49, 0xC1, 0x18, 0xA9, 0x4D at 2-cycle spacing.
  - For 0xA9: opcode=2, rs=2, rt=2, rd=1.
  - Then halted=1, retired=5, pc=4.
- Single-step: run=0. Three step pulses, each 3 cycles high, separated by 4 cycles low -> exactly 3 instructions (0x49, 0xC1, 0x18) issued, then IDLE with pc=3. Holding step high issues nothing extra.
- Backpressure: exec_ready=0 for 5 cycles while ir=0xC1 -> ir_valid stays 1, ir stays 0xC1, pc=1, retired unchanged. Raise exec_ready -> accepted, retired+1.
- Restart: assert restart in HALT -> next cycle halted=0, pc=0, state IDLE, retired=5 kept. run=1 -> 0x49 issued again, retired=6 after accept.
- Priority and corners:
  - restart and step_rise on the same edge -> IDLE, pc=0, no fetch.
  - Async reset mid-ISSUE -> ir_valid=0 with no clock edge.
  - PROG_LEN=1 -> halts after one accept of 0x49.
